seg_value_encoder: RTL and testbench
====================================

SEG_VALUE_ENCODER -- requirements
Module: seg_value_encoder

Interface
REQ-001 Parameter W, default 16: width of the unsigned binary input value.
REQ-002 Parameter DIGITS, default 5: number of decimal digits produced; SHALL satisfy 10^DIGITS > 2^W-1, and a violating value is a static elaboration error.
REQ-003 clk  input  1: single clock; all state SHALL be updated on its rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 value  input  W: unsigned binary value to convert, sampled on the accepted start cycle only.
REQ-006 start  input  1: conversion request, single-cycle or level; acted on only in IDLE.
REQ-007 busy  output  1: high while a conversion is in progress.
REQ-008 done  output  1: one-cycle pulse when seg_data holds the new result.
REQ-009 seg_data  output  7*DIGITS: segment codes for the display renderer; digit k (k=0 least significant) occupies bits [7k+6:7k] as {a,b,c,d,e,f,g}, active-high.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT, ENCODE.
REQ-011 IDLE: start=1 at edge T SHALL capture value into a W-bit shift register, clear the 4*DIGITS-bit BCD register and the W-bit iteration counter, and enter SHIFT.
REQ-012 SHIFT: each cycle, every BCD nibble >=5 SHALL first be incremented by 3, then {BCD,shift} SHALL be shifted left by one bit.
REQ-013 SHIFT SHALL last exactly W cycles (counter 0..W-1) and then enter ENCODE.
REQ-014 ENCODE SHALL last one cycle, register all DIGITS segment codes into seg_data, pulse done, and return to IDLE.
REQ-015 Latency: with start accepted at edge T, the new seg_data and done=1 SHALL both be visible in the cycle after edge T+W+1, i.e. W+2 cycles after start.
REQ-016 busy SHALL be 1 in SHIFT and ENCODE and 0 in IDLE; done SHALL be 0 in every other cycle.
REQ-017 start while busy=1 SHALL be ignored, with no queuing; start held high SHALL begin a new conversion on the first IDLE cycle after done.
REQ-018 seg_data SHALL hold its previous result for the whole conversion and change only at ENCODE.
REQ-019 Digit codes (hex of {a..g}):
- 0=7E, 1=30, 2=6D, 3=79, 4=33
- 5=5B, 6=5F, 7=70, 8=7F, 9=7B
- blank=00
- A BCD nibble >9 cannot occur; if one does, it SHALL encode as blank.
REQ-020 value changes outside the accepted start cycle SHALL have no effect.

Reset
REQ-021 rst=1 SHALL immediately force:
- FSM to IDLE
- busy=0, done=0
- seg_data to all digits blank (00)
- shift, BCD and counter registers to 0
REQ-022 rst asserted mid-conversion SHALL abort it; no done SHALL follow, and seg_data SHALL be blank.
REQ-023 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN:
- Defined: at ENCODE, every zero digit more significant than the most significant nonzero digit SHALL encode as 00; digit 0 SHALL always be shown, so value 0 displays a single "0".
- Undefined: all DIGITS digits SHALL be shown, including leading zeros as 7E.

Verification (W=16, DIGITS=5)
REQ-025 start at T with value=1234, LEADING_ZERO_BLANK_EN defined -> done=1 at T+18; seg_data digits 4..0 = 00,30,6D,79,33; busy high T+1..T+17.
REQ-026 value=0, LEADING_ZERO_BLANK_EN defined -> digits 4..0 = 00,00,00,00,7E; same value with the macro undefined -> 7E,7E,7E,7E,7E.
REQ-027 value=65535 -> digits 4..0 = 5F,5B,5B,79,5B; value=10000 -> 30,7E,7E,7E,7E in both configurations.
REQ-028 Second start with value=9 pulsed during busy -> ignored; one done pulse only, seg_data still holds the prior result; start held high -> back-to-back conversions with done every 19 cycles.
REQ-029 rst pulsed at T+8 of a conversion -> busy=0 immediately, seg_data=all 00, no done; a following start with value=42 -> done after 18 cycles with digits 00,00,00,33,6D (macro defined).

Source files
------------

// File: rtl/seg_value_encoder_if.sv
// seg_value_encoder_if: start/value request and busy/done/segment result bundle for seg_value_encoder
interface seg_value_encoder_if #(parameter int W = 16, parameter int DIGITS = 5);
  logic [W-1:0]        value;
  logic                start;
  logic                busy;
  logic                done;
  logic [7*DIGITS-1:0] seg_data;
  modport master(output value, start, input busy, done, seg_data);
  modport slave(input value, start, output busy, done, seg_data);
endinterface

// File: rtl/seg_value_encoder.sv
// seg_value_encoder: binary to 7-segment digits via shift-and-add-3; LEADING_ZERO_BLANK_EN blanks leading zero digits
module seg_value_encoder #(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input logic             clk,
  input logic             rst,
  seg_value_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;
  function automatic bit digits_ok();
    logic [W+4:0] p, m;
    p = (W+5)'(1);
    m = {5'd0, {W{1'b1}}};
    for (int i = 0; i < DIGITS; i++) if (p <= m) p = p * (W+5)'(10);
    return p > m;
  endfunction
  if (!digits_ok()) begin : g_digits_too_small
    $error("seg_value_encoder: DIGITS cannot represent 2^W-1");
  end
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: seg7 = 7'h7E;
      4'd1: seg7 = 7'h30;
      4'd2: seg7 = 7'h6D;
      4'd3: seg7 = 7'h79;
      4'd4: seg7 = 7'h33;
      4'd5: seg7 = 7'h5B;
      4'd6: seg7 = 7'h5F;
      4'd7: seg7 = 7'h70;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h7B;
      default: seg7 = 7'h00;
    endcase
  endfunction
  state_t              r_state, w_next;
  logic [W-1:0]        r_sh, r_cnt;
  logic [4*DIGITS-1:0] r_bcd, w_adj;
  logic [7*DIGITS-1:0] r_seg, w_seg;
  logic                r_done, w_accept;
`ifdef LEADING_ZERO_BLANK_EN
  logic                w_lz;
`endif
  // the done cycle itself never accepts, so a held start restarts one cycle later
  assign w_accept     = bus.start && !r_done;
  assign bus.busy     = r_state != IDLE;
  assign bus.done     = r_done;
  assign bus.seg_data = r_seg;
  always_comb begin
    w_next = r_state == IDLE  ? (w_accept ? SHIFT : IDLE) :
             r_state == SHIFT ? (r_cnt == W'(W-1) ? ENCODE : SHIFT) : IDLE;
  end
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++)
      if (r_bcd[4*k+:4] >= 4'd5) w_adj[4*k+:4] = r_bcd[4*k+:4] + 4'd3;
  end
  always_comb begin
    w_seg = '0;
`ifdef LEADING_ZERO_BLANK_EN
    w_lz = 1'b1;
`endif
    for (int k = DIGITS-1; k >= 0; k--) begin
      w_seg[7*k+:7] = seg7(r_bcd[4*k+:4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (w_lz && r_bcd[4*k+:4] == 4'd0 && k != 0) w_seg[7*k+:7] = 7'h00;
      w_lz = w_lz && r_bcd[4*k+:4] == 4'd0;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_seg   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == ENCODE;
      if (r_state == IDLE && w_accept) begin
        r_sh  <= bus.value;
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_bcd <= {w_adj[4*DIGITS-2:0], r_sh[W-1]};
        r_sh  <= {r_sh[W-2:0], 1'b0};
        r_cnt <= r_cnt + W'(1);
      end
      if (r_state == ENCODE) r_seg <= w_seg;
    end
  end
endmodule

// File: tb/tb_seg_value_encoder.sv
// tb_seg_value_encoder: random and directed conversions scored against a decimal-arithmetic display model
module tb_seg_value_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passes = 0;
  logic [34:0] q[$];
  logic [34:0] last_exp = '0;
  logic [6:0] lut[10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  seg_value_encoder_if #(.W(16), .DIGITS(5)) bus();
  seg_value_encoder #(.W(16), .DIGITS(5)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask
  function automatic logic [34:0] model(input int v);
    int d[5];
    int top = 0;
    logic [34:0] r = '0;
    for (int k = 0; k < 5; k++) begin
      d[k] = v % 10;
      v = v / 10;
      if (d[k] != 0) top = k;
    end
    for (int k = 0; k < 5; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
      r[7*k+:7] = k > top ? 7'h00 : lut[d[k]];
`else
      r[7*k+:7] = lut[d[k]];
`endif
    end
    return r;
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("seg_data", {29'd0, bus.seg_data}, {29'd0, q.pop_front()});
    end
  end
  task automatic convert(input logic [15:0] v, input string nm, input bit poke);
    int k;
    logic [34:0] prev;
    @(posedge clk);
    @(negedge clk);
    bus.value = v;
    bus.start = 1'b1;
    prev = last_exp;
    last_exp = model(int'(v));
    q.push_back(last_exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.value = 16'($urandom);
    chk({nm, "_busy"}, {63'd0, bus.busy}, 1);
    k = 0;
    while (!bus.done && k < 100) begin
      @(posedge clk);
      #1 k++;
      if (poke && k == 5) begin bus.start = 1'b1; bus.value = 16'd9; end
      if (poke && k == 6) bus.start = 1'b0;
      if (poke && k == 8) chk({nm, "_hold"}, {29'd0, bus.seg_data}, {29'd0, prev});
    end
    chk({nm, "_latency"}, k, 17);
    chk({nm, "_busy_at_done"}, {63'd0, bus.busy}, 0);
  endtask
  initial begin
    int k;
    bus.start = 1'b0;
    bus.value = '0;
    repeat (2) @(posedge clk);
    #1 chk("rst_busy", {63'd0, bus.busy}, 0);
    chk("rst_done", {63'd0, bus.done}, 0);
    chk("rst_seg", {29'd0, bus.seg_data}, 0);
    @(negedge clk) rst = 1'b0;
    convert(16'd1234, "v1234", 0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("v1234_lit", {29'd0, bus.seg_data}, {29'd0, 7'h00, 7'h30, 7'h6D, 7'h79, 7'h33});
`else
    chk("v1234_lit", {29'd0, bus.seg_data}, {29'd0, 7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33});
`endif
    convert(16'd0, "v0", 0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("v0_lit", {29'd0, bus.seg_data}, {29'd0, 7'h00, 7'h00, 7'h00, 7'h00, 7'h7E});
`else
    chk("v0_lit", {29'd0, bus.seg_data}, {29'd0, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E});
`endif
    convert(16'd65535, "v65535", 0);
    chk("v65535_lit", {29'd0, bus.seg_data}, {29'd0, 7'h5F, 7'h5B, 7'h5B, 7'h79, 7'h5B});
    convert(16'd10000, "v10000", 0);
    chk("v10000_lit", {29'd0, bus.seg_data}, {29'd0, 7'h30, 7'h7E, 7'h7E, 7'h7E, 7'h7E});
    convert(16'd31415, "poke", 1);
    for (int i = 0; i < 20; i++) convert(16'($urandom_range(0, 65535)), "rand", 0);
    @(posedge clk);
    @(negedge clk);
    bus.value = 16'd777;
    bus.start = 1'b1;
    last_exp = model(777);
    q.push_back(last_exp);
    q.push_back(last_exp);
    k = 0;
    while (!bus.done && k < 100) begin @(posedge clk); #1 k++; end
    chk("held_first_latency", k, 18);
    k = 0;
    do begin @(posedge clk); #1 k++; end while (!bus.done && k < 100);
    chk("held_period", k, 19);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.value = 16'd500;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abort_busy", {63'd0, bus.busy}, 0);
    chk("abort_done", {63'd0, bus.done}, 0);
    chk("abort_seg", {29'd0, bus.seg_data}, 0);
    @(negedge clk) rst = 1'b0;
    last_exp = '0;
    repeat (25) @(posedge clk);
    convert(16'd42, "v42", 0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("v42_lit", {29'd0, bus.seg_data}, {29'd0, 7'h00, 7'h00, 7'h00, 7'h33, 7'h6D});
`endif
    repeat (25) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
